// File: rtl/nasti_ddrx_req_splitter.sv
// Pops NASTI AR/AW burst descriptors (round-robin), maps the byte address onto
// DDR bank/row/column and issues one column command per beat to the scheduler.
module nasti_ddrx_req_splitter #(
    parameter int C_NASTI_ID_WIDTH   = 9,
    parameter int C_NASTI_ADDR_WIDTH = 32,
    parameter int C_NASTI_DATA_WIDTH = 64,
    parameter int C_ROW_WIDTH        = 16,
    parameter int C_BANK_WIDTH       = 3,
    parameter int C_COL_WIDTH        = 10
) (
    input  logic                          core_clk,
    input  logic                          core_arst,
    input  logic [1:0]                    add_map,
    input  logic                          rempty_ar,
    output logic                          rinc_ar,
    input  logic [C_NASTI_ID_WIDTH-1:0]   ar_id,
    input  logic [C_NASTI_ADDR_WIDTH-1:0] ar_addr,
    input  logic [7:0]                    ar_len,
    input  logic                          rempty_aw,
    output logic                          rinc_aw,
    input  logic [C_NASTI_ID_WIDTH-1:0]   aw_id,
    input  logic [C_NASTI_ADDR_WIDTH-1:0] aw_addr,
    input  logic [7:0]                    aw_len,
    output logic                          cmd_valid,
    input  logic                          cmd_ready,
    output logic                          cmd_write,
    output logic [C_NASTI_ID_WIDTH-1:0]   cmd_id,
    output logic [C_BANK_WIDTH-1:0]       cmd_bank,
    output logic [C_ROW_WIDTH-1:0]        cmd_row,
    output logic [C_COL_WIDTH-1:0]        cmd_col,
    output logic                          cmd_last,
    output logic                          busy
);
    localparam int OFS   = $clog2(C_NASTI_DATA_WIDTH / 8);
    localparam int BEATW = C_NASTI_ADDR_WIDTH - OFS;

    typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST} state_t;

    state_t                      state_q, state_d;
    logic [C_NASTI_ID_WIDTH-1:0] id_q, id_d;
    logic [C_BANK_WIDTH-1:0]     bank_q, bank_d;
    logic [C_ROW_WIDTH-1:0]      row_q, row_d;
    logic [C_COL_WIDTH-1:0]      col_q, col_d;
    logic [7:0]                  rem_q, rem_d;
    logic                        write_q, write_d;
    logic                        last_wr_q, last_wr_d;
    logic                        hold_q, hold_d;

    logic                          pick_ar, pick_aw;
    logic [C_NASTI_ADDR_WIDTH-1:0] pop_addr;
    logic [BEATW-1:0]              a_beat;
    logic [C_BANK_WIDTH-1:0]       map_bank;
    logic [C_ROW_WIDTH-1:0]        map_row;
    logic                          unused_ofs;

    assign pop_addr   = pick_aw ? aw_addr : ar_addr;
    assign a_beat     = pop_addr[C_NASTI_ADDR_WIDTH-1:OFS];
    assign unused_ofs = ^pop_addr[OFS-1:0];

    always_comb begin
        map_bank = a_beat[C_COL_WIDTH +: C_BANK_WIDTH];
        map_row  = a_beat[C_COL_WIDTH+C_BANK_WIDTH +: C_ROW_WIDTH];
        if (add_map == 2'd1) begin
            map_row  = a_beat[C_COL_WIDTH +: C_ROW_WIDTH];
            map_bank = a_beat[C_COL_WIDTH+C_ROW_WIDTH +: C_BANK_WIDTH];
        end
    end

    // hold_q enforces the dead cycle between the last beat and the next pop.
    always_comb begin
        pick_ar = 1'b0;
        pick_aw = 1'b0;
        if (state_q == IDLE && !hold_q) begin
            if (!rempty_ar && (rempty_aw || last_wr_q))
                pick_ar = 1'b1;
            else if (!rempty_aw)
                pick_aw = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        bank_d    = bank_q;
        row_d     = row_q;
        col_d     = col_q;
        rem_d     = rem_q;
        write_d   = write_q;
        last_wr_d = last_wr_q;
        hold_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_ar || pick_aw) begin
                    state_d = pick_aw ? WR_BURST : RD_BURST;
                    write_d = pick_aw;
                    id_d    = pick_aw ? aw_id : ar_id;
                    rem_d   = pick_aw ? aw_len : ar_len;
                    col_d   = a_beat[C_COL_WIDTH-1:0];
                    bank_d  = map_bank;
                    row_d   = map_row;
                end
            end
            RD_BURST, WR_BURST: begin
                if (cmd_ready) begin
                    if (rem_q == 8'd0) begin
                        state_d   = IDLE;
                        hold_d    = 1'b1;
                        last_wr_d = (state_q == WR_BURST);
                    end else begin
                        col_d = col_q + 1'b1;
                        rem_d = rem_q - 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // last_wr_q resets to 1 so the first contested grant goes to the read side.
    always_ff @(posedge core_clk or posedge core_arst) begin
        if (core_arst) begin
            state_q   <= IDLE;
            id_q      <= '0;
            bank_q    <= '0;
            row_q     <= '0;
            col_q     <= '0;
            rem_q     <= '0;
            write_q   <= 1'b0;
            last_wr_q <= 1'b1;
            hold_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            bank_q    <= bank_d;
            row_q     <= row_d;
            col_q     <= col_d;
            rem_q     <= rem_d;
            write_q   <= write_d;
            last_wr_q <= last_wr_d;
            hold_q    <= hold_d;
        end
    end

    assign rinc_ar   = pick_ar;
    assign rinc_aw   = pick_aw;
    assign busy      = (state_q != IDLE);
    assign cmd_valid = busy;
    assign cmd_write = write_q;
    assign cmd_id    = id_q;
    assign cmd_bank  = bank_q;
    assign cmd_row   = row_q;
    assign cmd_col   = col_q;
    assign cmd_last  = busy && (rem_q == 8'd0);

endmodule

// File: tb/tb_nasti_ddrx_req_splitter.sv
// Scoreboard bench: directed AR/AW FIFO vectors push expected commands; a
// negedge monitor pops and compares every accepted command.
module tb_nasti_ddrx_req_splitter;
    logic        core_clk = 1'b0;
    logic        core_arst;
    logic [1:0]  add_map;
    logic        rempty_ar, rinc_ar, rempty_aw, rinc_aw;
    logic [8:0]  ar_id, aw_id;
    logic [31:0] ar_addr, aw_addr;
    logic [7:0]  ar_len, aw_len;
    logic        cmd_valid, cmd_ready, cmd_write, cmd_last, busy;
    logic [8:0]  cmd_id;
    logic [2:0]  cmd_bank;
    logic [15:0] cmd_row;
    logic [9:0]  cmd_col;

    nasti_ddrx_req_splitter dut (
        .core_clk(core_clk), .core_arst(core_arst), .add_map(add_map),
        .rempty_ar(rempty_ar), .rinc_ar(rinc_ar), .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len),
        .rempty_aw(rempty_aw), .rinc_aw(rinc_aw), .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_id(cmd_id),
        .cmd_bank(cmd_bank), .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_last(cmd_last), .busy(busy)
    );

    always #5 core_clk = ~core_clk;

    typedef struct { logic [8:0] id; logic [31:0] addr; logic [7:0] len; } ent_t;
    typedef struct { logic w; logic [8:0] id; logic [2:0] bank; logic [15:0] row; logic [9:0] col; logic last; } exp_t;

    ent_t arq[$];
    ent_t awq[$];
    exp_t sb[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_done = -1;
    bit arb_phase = 0;
    bit toggle = 0;
    bit p_ar = 0, p_aw = 0;
    bit popped_prev = 0, stall_prev = 0;
    logic [39:0] held;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic refresh();
        rempty_ar = (arq.size() == 0);
        rempty_aw = (awq.size() == 0);
        if (arq.size() != 0) begin ar_id = arq[0].id; ar_addr = arq[0].addr; ar_len = arq[0].len; end
        if (awq.size() != 0) begin aw_id = awq[0].id; aw_addr = awq[0].addr; aw_len = awq[0].len; end
    endtask

    task automatic exp_push(input logic w, input logic [8:0] id, input logic [2:0] bank,
                            input logic [15:0] row, input logic [9:0] col, input logic last);
        exp_t e;
        e.w = w; e.id = id; e.bank = bank; e.row = row; e.col = col; e.last = last;
        sb.push_back(e);
    endtask

    // Linear burst starting at col0; none of these callers cross the row end.
    task automatic exp_burst(input logic w, input logic [8:0] id, input logic [2:0] bank,
                             input logic [15:0] row, input logic [9:0] col0, input int len);
        logic [9:0] c;
        c = col0;
        for (int i = 0; i <= len; i++) begin
            exp_push(w, id, bank, row, c, i == len);
            c = c + 10'd1;
        end
    endtask

    task automatic wait_drain(input int budget, input string name);
        bit done;
        done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge core_clk); #1;
            if (sb.size() == 0 && !busy && !cmd_valid) done = 1;
        end
        if (!done) begin
            tests++; fails++;
            $display("FAIL %s: drain timeout, %0d commands outstanding", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic stim_slot();
        @(posedge core_clk); #2;
    endtask

    // FIFO model: pop on the edge after rinc was seen high.
    always @(posedge core_clk) begin
        #1;
        if (p_ar && arq.size() != 0) void'(arq.pop_front());
        if (p_aw && awq.size() != 0) void'(awq.pop_front());
        refresh();
    end

    always @(posedge core_clk) begin
        #1;
        if (toggle) cmd_ready = ~cmd_ready;
    end

    always @(negedge core_clk) begin
        cyc++;
        if (core_arst) begin
            p_ar = 0; p_aw = 0; popped_prev = 0; stall_prev = 0; last_done = -1;
        end else begin
            if (rinc_ar && rinc_aw) chk("rinc_onehot", {rinc_ar, rinc_aw}, 2'b00);
            if (popped_prev) chk("first_valid", cmd_valid, 1'b1);
            if (stall_prev) chk("stall_hold", {cmd_valid, held}, {1'b1, held_now()});
            if (rinc_ar || rinc_aw) begin
                if (last_done >= 0) begin
                    if (arb_phase) chk("pop_gap", cyc - last_done, 2);
                    else chk("pop_gap_min", (cyc - last_done) >= 2, 1'b1);
                end
                popped_prev = 1;
            end else begin
                popped_prev = 0;
            end
            p_ar = rinc_ar;
            p_aw = rinc_aw;
            if (cmd_valid && cmd_ready) begin
                if (sb.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL cmd: unexpected command col=%0h id=%0h", cmd_col, cmd_id);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("cmd", held_now(), {e.w, e.id, e.bank, e.row, e.col, e.last});
                end
                if (cmd_last) last_done = cyc;
            end
            stall_prev = cmd_valid && !cmd_ready;
            held = held_now();
        end
    end

    function automatic logic [39:0] held_now();
        return {cmd_write, cmd_id, cmd_bank, cmd_row, cmd_col, cmd_last};
    endfunction

    initial begin
        ent_t t;
        core_arst = 1'b1; cmd_ready = 1'b0; add_map = 2'd0;
        ar_id = '0; ar_addr = '0; ar_len = '0; aw_id = '0; aw_addr = '0; aw_len = '0;
        refresh();
        repeat (3) @(negedge core_clk);
        chk("reset_outputs", {rinc_ar, rinc_aw, cmd_valid, busy, held_now()}, 44'd0);

        stim_slot();
        core_arst = 1'b0; cmd_ready = 1'b1;

        // single read, map 0
        stim_slot();
        t.id = 9'h05; t.addr = 32'h0001_2348; t.len = 8'd0; arq.push_back(t); refresh();
        exp_push(1'b0, 9'h05, 3'd1, 16'd1, 10'h069, 1'b1);
        wait_drain(50, "single_read");
        chk("busy_idle", busy, 1'b0);

        // same address through AW, map 1
        stim_slot();
        add_map = 2'd1;
        t.id = 9'h0A; t.addr = 32'h0001_2348; t.len = 8'd0; awq.push_back(t); refresh();
        exp_push(1'b1, 9'h0A, 3'd0, 16'd9, 10'h069, 1'b1);
        wait_drain(50, "single_write_map1");

        // reserved map value decodes as map 0
        stim_slot();
        add_map = 2'd3;
        t.id = 9'h0C; t.addr = 32'h0001_2348; t.len = 8'd0; arq.push_back(t); refresh();
        exp_push(1'b0, 9'h0C, 3'd1, 16'd1, 10'h069, 1'b1);
        wait_drain(50, "map_reserved");

        // backpressure, ready toggling
        stim_slot();
        add_map = 2'd0; toggle = 1;
        t.id = 9'h11; t.addr = 32'h0; t.len = 8'd3; arq.push_back(t); refresh();
        exp_burst(1'b0, 9'h11, 3'd0, 16'd0, 10'h000, 3);
        wait_drain(100, "backpressure");
        toggle = 0;
        stim_slot();
        cmd_ready = 1'b1;

        // column wrap inside the row
        stim_slot();
        t.id = 9'h1F; t.addr = 32'h0000_1FF0; t.len = 8'd3; awq.push_back(t); refresh();
        exp_push(1'b1, 9'h1F, 3'd0, 16'd0, 10'h3FE, 1'b0);
        exp_push(1'b1, 9'h1F, 3'd0, 16'd0, 10'h3FF, 1'b0);
        exp_push(1'b1, 9'h1F, 3'd0, 16'd0, 10'h000, 1'b0);
        exp_push(1'b1, 9'h1F, 3'd0, 16'd0, 10'h001, 1'b1);
        wait_drain(50, "col_wrap");

        // maximum length burst
        stim_slot();
        t.id = 9'h1AB; t.addr = 32'h0; t.len = 8'd255; arq.push_back(t); refresh();
        exp_burst(1'b0, 9'h1AB, 3'd0, 16'd0, 10'h000, 255);
        wait_drain(600, "len255");

        // round-robin from reset: R,W,R,W,R,W with minimum pop spacing
        stim_slot();
        core_arst = 1'b1;
        repeat (2) stim_slot();
        core_arst = 1'b0; arb_phase = 1;
        for (int i = 0; i < 3; i++) begin
            t.id = 9'h100 + 9'(i); t.addr = 32'(i * 8); t.len = 8'd0; arq.push_back(t);
            t.id = 9'h080 + 9'(i); t.addr = 32'h0000_2008; awq.push_back(t);
        end
        refresh();
        for (int i = 0; i < 3; i++) begin
            exp_push(1'b0, 9'h100 + 9'(i), 3'd0, 16'd0, 10'(i), 1'b1);
            exp_push(1'b1, 9'h080 + 9'(i), 3'd1, 16'd0, 10'h001, 1'b1);
        end
        wait_drain(100, "arbitration");
        arb_phase = 0;

        // reset in the middle of an 8-beat read
        stim_slot();
        t.id = 9'h33; t.addr = 32'h0; t.len = 8'd7; arq.push_back(t); refresh();
        exp_burst(1'b0, 9'h33, 3'd0, 16'd0, 10'h000, 7);
        begin
            bit hit;
            hit = 0;
            for (int i = 0; i < 50 && !hit; i++) begin
                stim_slot();
                if (sb.size() == 6) hit = 1;
            end
            chk("reach_beat2", hit, 1'b1);
        end
        core_arst = 1'b1;
        #1;
        chk("rst_mid_valid", cmd_valid, 1'b0);
        chk("rst_mid_busy", busy, 1'b0);
        sb.delete();
        repeat (2) stim_slot();
        core_arst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge core_clk);
            chk("post_rst_quiet", {cmd_valid, rinc_ar, rinc_aw}, 3'b000);
        end

        // fresh pop after reset recovery
        stim_slot();
        t.id = 9'h44; t.addr = 32'h0001_2348; t.len = 8'd1; arq.push_back(t); refresh();
        exp_burst(1'b0, 9'h44, 3'd1, 16'd1, 10'h069, 1);
        wait_drain(50, "after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
